// File: rtl/perceptron_accum_if.sv
// perceptron_accum_if: term/threshold input and result output bundle for perceptron_accum
interface perceptron_accum_if #(
  parameter int SUM_W = 6,
  parameter int ACC_W = 8
);
  logic             start;
  logic [ACC_W-1:0] threshold;
  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic             busy;
  logic             out_valid;
  logic [ACC_W-1:0] acc;
  logic             fire;
  modport master (
    output start, threshold, in_valid, in_sum,
    input  busy, out_valid, acc, fire
  );
  modport slave (
    input  start, threshold, in_valid, in_sum,
    output busy, out_valid, acc, fire
  );
endinterface

// File: rtl/perceptron_accum.sv
// perceptron_accum: saturating accumulation of N_TERMS partial sums with a threshold fire decision
module perceptron_accum #(
  parameter int SUM_W   = 6,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input logic clk,
  input logic rst,
  perceptron_accum_if.slave bus
);
  localparam int CW = $clog2(N_TERMS);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] acc, thr, acc_sat;
  logic [ACC_W:0]   sum;
  logic             fire, take, last;
  always_comb begin
    sum      = {1'b0, acc} + (ACC_W+1)'(bus.in_sum);
    acc_sat  = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    take     = state == ACCUM && bus.in_valid;
    last     = take && cnt == CW'(N_TERMS-1);
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.start ? ACCUM : IDLE;
      ACCUM:   state_nx = last ? DONE : ACCUM;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  // fire is decided on the last-term edge so it lines up with out_valid
  always_ff @(posedge clk)
    if (rst) begin
      acc  <= '0;
      cnt  <= '0;
      thr  <= '0;
      fire <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      acc  <= '0;
      cnt  <= '0;
      thr  <= bus.threshold;
      fire <= 1'b0;
    end else if (take) begin
      acc <= acc_sat;
      cnt <= cnt + 1'b1;
      if (last) fire <= acc_sat >= thr;
    end
  assign bus.busy      = state != IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.acc       = acc;
  assign bus.fire      = fire;
endmodule

// File: tb/tb_perceptron_accum.sv
// tb_perceptron_accum: drives an 8-bit and a 7-bit accumulator in lockstep against a queue-based model
module tb_perceptron_accum;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] thr = '0;
  logic       in_valid = 1'b0;
  logic [5:0] in_sum = '0;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  perceptron_accum_if #(.SUM_W(6), .ACC_W(8)) ifa ();
  perceptron_accum_if #(.SUM_W(6), .ACC_W(7)) ifb ();
  assign ifa.start     = start;
  assign ifa.threshold = thr;
  assign ifa.in_valid  = in_valid;
  assign ifa.in_sum    = in_sum;
  assign ifb.start     = start;
  assign ifb.threshold = thr[6:0];
  assign ifb.in_valid  = in_valid;
  assign ifb.in_sum    = in_sum;
  perceptron_accum #(.SUM_W(6), .N_TERMS(4), .ACC_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  perceptron_accum #(.SUM_W(6), .N_TERMS(4), .ACC_W(7)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic int model(input int terms[$], input int w);
    int s = 0;
    int lim = (1 << w) - 1;
    foreach (terms[i]) s = (s + terms[i] > lim) ? lim : s + terms[i];
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int ea, input int fa, input int eb, input int fb);
    chk({tag, "_ov_a"}, 32'(ifa.out_valid), 0);
    chk({tag, "_busy_a"}, 32'(ifa.busy), 0);
    chk({tag, "_acc_a"}, 32'(ifa.acc), ea);
    chk({tag, "_fire_a"}, 32'(ifa.fire), fa);
    chk({tag, "_ov_b"}, 32'(ifb.out_valid), 0);
    chk({tag, "_busy_b"}, 32'(ifb.busy), 0);
    chk({tag, "_acc_b"}, 32'(ifb.acc), eb);
    chk({tag, "_fire_b"}, 32'(ifb.fire), fb);
  endtask

  // poke pulses start with threshold 0 during gaps; the latched threshold must win
  task automatic run(input string tag, input logic [7:0] t, input int terms[$], input int gaps[$], input bit poke);
    int ea = model(terms, 8);
    int eb = model(terms, 7);
    int fa = (ea >= int'(t)) ? 1 : 0;
    int fb = (eb >= int'(t[6:0])) ? 1 : 0;
    start = 1'b1; thr = t; in_valid = 1'b0;
    step();
    start = 1'b0;
    chk({tag, "_busy_start_a"}, 32'(ifa.busy), 1);
    chk({tag, "_busy_start_b"}, 32'(ifb.busy), 1);
    foreach (terms[i]) begin
      repeat (gaps[i]) begin
        in_valid = 1'b0;
        if (poke) begin start = 1'b1; thr = '0; end
        step();
        start = 1'b0; thr = t;
        chk({tag, "_gap_ov_a"}, 32'(ifa.out_valid), 0);
        chk({tag, "_gap_ov_b"}, 32'(ifb.out_valid), 0);
      end
      in_valid = 1'b1; in_sum = 6'(terms[i]);
      step();
      in_valid = 1'b0;
      if (i < terms.size() - 1) begin
        chk({tag, "_term_ov_a"}, 32'(ifa.out_valid), 0);
        chk({tag, "_term_busy_a"}, 32'(ifa.busy), 1);
        chk({tag, "_term_ov_b"}, 32'(ifb.out_valid), 0);
      end
    end
    chk({tag, "_ov_a"}, 32'(ifa.out_valid), 1);
    chk({tag, "_done_busy_a"}, 32'(ifa.busy), 1);
    chk({tag, "_acc_a"}, 32'(ifa.acc), ea);
    chk({tag, "_fire_a"}, 32'(ifa.fire), fa);
    chk({tag, "_ov_b"}, 32'(ifb.out_valid), 1);
    chk({tag, "_acc_b"}, 32'(ifb.acc), eb);
    chk({tag, "_fire_b"}, 32'(ifb.fire), fb);
    start = 1'b1; in_valid = 1'b1; in_sum = 6'd63;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk_idle({tag, "_after"}, ea, fa, eb, fb);
  endtask

  initial begin
    int q[$];
    int g[$];
    int e;
    step();
    step();
    chk_idle("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk_idle("reset_hold", 0, 0, 0, 0);
    q = '{30, 25, 32, 24}; g = '{0, 0, 0, 0};
    run("basic", 8'd100, q, g, 1'b0);
    run("nofire", 8'd112, q, g, 1'b0);
    run("equal", 8'd111, q, g, 1'b0);
    q = '{45, 0, 45, 45}; g = '{0, 3, 1, 0};
    run("gapped", 8'd140, q, g, 1'b1);
    q = '{45, 45, 45, 45}; g = '{0, 0, 0, 0};
    run("sat", 8'd200, q, g, 1'b0);
    run("sat_eq", 8'd127, q, g, 1'b0);
    start = 1'b1; thr = 8'd10;
    step();
    start = 1'b0;
    in_valid = 1'b1; in_sum = 6'd30;
    step();
    in_sum = 6'd25;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst", 0, 0, 0, 0);
    step();
    chk_idle("midrst_after", 0, 0, 0, 0);
    q = '{1, 2, 3, 4}; g = '{0, 0, 0, 0};
    run("fresh", 8'd10, q, g, 1'b0);
    repeat (5) begin
      in_valid = 1'b1; in_sum = 6'd63;
      step();
      chk_idle("idle_hold", 10, 1, 10, 1);
    end
    in_valid = 1'b0;
    repeat (25) begin
      q = {}; g = {};
      repeat (4) begin
        q.push_back(int'($urandom_range(0, 63)));
        g.push_back(int'($urandom_range(0, 2)));
      end
      e = model(q, 8);
      run("rand", (e > 0 && $urandom_range(0, 1) == 1) ? 8'(e) : 8'($urandom_range(0, 255)), q, g, 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
